// File: rtl/loader_pkg.sv
// Shared types and helpers for the RAM loader: FSM states, frame header byte
// and the word-count decode.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_CHECK   = 3'd4
    } loader_state_t;

    localparam logic [7:0] LOADER_HEADER = 8'hA5;

    // A count byte of zero stands for a full 256-word frame.
    function automatic logic [8:0] word_count(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-interval counter: counts cycles without a byte while enabled and flags
// expiry on the TIMEOUT_CYCLES-th idle cycle unless a byte arrives that cycle.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic CLK_50,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            idle_cnt <= '0;
        end else if (clear || !enable) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TERM_CNT) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    // An arriving byte takes priority over expiry in the same cycle.
    assign expire = enable && !clear && (idle_cnt == TERM_CNT);

endmodule

// File: rtl/ram_loader.sv
// Fills the CPU data RAM from a framed byte stream (A5, N, {hi,lo} x W, csum),
// stalling the CPU for the duration of each frame.
//
// state      | meaning
// IDLE       | waiting for header byte A5
// COUNT      | next byte is the word count N
// DATA_HI    | next byte is a word's high byte
// DATA_LO    | next byte is a word's low byte, triggers the RAM write
// CHECK      | next byte is the checksum
module ram_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  CLK_50,
    input  logic                  resetN,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_wdata,
    output logic                  cpu_holdN,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    loader_state_t         state_q, state_d;
    logic [8:0]            wcnt_q, wcnt_d;
    logic [8:0]            idx_q, idx_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            hi_q, hi_d;
    logic                  ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic [15:0]           ram_wdata_d;
    logic                  done_d, error_d;
    logic                  expire;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK_50 (CLK_50),
        .resetN (resetN),
        .clear  (rx_valid),
        .enable (busy),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        hi_d        = hi_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        done_d      = done;
        error_d     = error;

        if (expire) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == LOADER_HEADER) begin
                        state_d = ST_COUNT;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        idx_d   = 9'd0;
                        sum_d   = 8'd0;
                    end
                end
                ST_COUNT: begin
                    wcnt_d  = word_count(rx_data);
                    state_d = ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    hi_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    sum_d       = sum_q + rx_data;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = BASE + ADDR_WIDTH'(idx_q);
                    ram_wdata_d = {hi_q, rx_data};
                    idx_d       = idx_q + 9'd1;
                    state_d     = (idx_q + 9'd1 == wcnt_q) ? ST_CHECK : ST_DATA_HI;
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (rx_data == sum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= 9'd0;
            idx_q     <= 9'd0;
            sum_q     <= 8'd0;
            hi_q      <= 8'd0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 16'd0;
            cpu_holdN <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            hi_q      <= hi_d;
            ram_we    <= ram_we_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            cpu_holdN <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            done      <= done_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: two instances (base 0 and base 1022) share
// one byte stream; expected RAM writes are queued and popped by a monitor.
module tb_ram_loader;

    localparam int AW     = 10;
    localparam int BASE_B = 1022;
    localparam int TMO    = 20;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          CLK_50;
    logic          resetN;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [15:0]   ram_wdata_a, ram_wdata_b;
    logic          cpu_holdN_a, cpu_holdN_b;
    logic          busy_a, busy_b;
    logic          done_a, done_b;
    logic          error_a, error_b;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t q_a[$];
    wr_t q_b[$];
    wr_t e_a, e_b;
    logic [15:0] words [256];

    ram_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .TIMEOUT_CYCLES(TMO)) u_dut_a (
        .CLK_50(CLK_50), .resetN(resetN), .rx_valid(rx_valid), .rx_data(rx_data),
        .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a),
        .cpu_holdN(cpu_holdN_a), .busy(busy_a), .done(done_a), .error(error_a)
    );

    ram_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE_B), .TIMEOUT_CYCLES(TMO)) u_dut_b (
        .CLK_50(CLK_50), .resetN(resetN), .rx_valid(rx_valid), .rx_data(rx_data),
        .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b),
        .cpu_holdN(cpu_holdN_b), .busy(busy_b), .done(done_b), .error(error_b)
    );

    initial CLK_50 = 1'b0;
    always #10 CLK_50 = ~CLK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Status vector {ram_we, cpu_holdN, busy, done, error}, checked on both instances.
    task automatic check_status(input string name, input logic [4:0] exp);
        check({name, "_a"}, {27'd0, ram_we_a, cpu_holdN_a, busy_a, done_a, error_a}, {27'd0, exp});
        check({name, "_b"}, {27'd0, ram_we_b, cpu_holdN_b, busy_b, done_b, error_b}, {27'd0, exp});
    endtask

    task automatic check_drained(input string name);
        check({name, "_qa"}, q_a.size(), 0);
        check({name, "_qb"}, q_b.size(), 0);
    endtask

    // Called at a negedge; returns at the next negedge so back-to-back calls give consecutive strobes.
    task automatic drive(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK_50);
        rx_valid = 1'b0;
    endtask

    task automatic expect_write(input int idx, input logic [15:0] data);
        q_a.push_back({AW'(idx), data});
        q_b.push_back({AW'(BASE_B + idx), data});
    endtask

    task automatic send_frame(input string name, input logic [7:0] n, input int w,
                              input logic [7:0] csum, input int gap, input logic [4:0] exp_end);
        drive(8'hA5);
        check_status({name, "_hdr"}, 5'b00100);
        drive(n);
        for (int i = 0; i < w; i++) begin
            drive(words[i][15:8]);
            repeat (gap) @(negedge CLK_50);
            expect_write(i, words[i]);
            drive(words[i][7:0]);
            check({name, "_we"}, {30'd0, ram_we_a, ram_we_b}, 32'd3);
            repeat (gap) @(negedge CLK_50);
        end
        drive(csum);
        check_status({name, "_end"}, exp_end);
        check_drained(name);
    endtask

    always @(negedge CLK_50) begin
        if (ram_we_a) begin
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_a: got write addr %h data %h, expected no write", ram_addr_a, ram_wdata_a);
            end else begin
                e_a = q_a.pop_front();
                check("wr_a", {6'd0, ram_addr_a, ram_wdata_a}, {6'd0, e_a.addr, e_a.data});
            end
        end
        if (ram_we_b) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_b: got write addr %h data %h, expected no write", ram_addr_b, ram_wdata_b);
            end else begin
                e_b = q_b.pop_front();
                check("wr_b", {6'd0, ram_addr_b, ram_wdata_b}, {6'd0, e_b.addr, e_b.data});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge CLK_50);
        check_status("reset", 5'b01000);
        check("reset_addr_a", {22'd0, ram_addr_a}, 32'd0);
        check("reset_addr_b", {22'd0, ram_addr_b}, 32'd0);
        check("reset_wdata", {ram_wdata_a, ram_wdata_b}, 32'd0);
        resetN = 1'b1;
        @(negedge CLK_50);

        drive(8'h00);
        drive(8'hFF);
        check_status("garbage", 5'b01000);

        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        send_frame("good", 8'h02, 2, 8'hBE, 0, 5'b01010);
        send_frame("badsum", 8'h02, 2, 8'hBF, 0, 5'b01001);

        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        send_frame("wrap", 8'h03, 3, 8'hCC, 2, 5'b01010);

        for (int i = 0; i < 256; i++) words[i] = 16'h0001;
        send_frame("n0", 8'h00, 256, 8'h00, 0, 5'b01010);

        // Silence after the high byte: still busy on the last idle cycle, aborted one edge later.
        drive(8'hA5);
        drive(8'h01);
        drive(8'h12);
        repeat (TMO - 1) @(negedge CLK_50);
        check_status("tmo_pre", 5'b00100);
        @(negedge CLK_50);
        check_status("tmo_abort", 5'b01001);
        check_drained("tmo");

        // A byte landing on the expiry cycle wins over the abort.
        drive(8'hA5);
        drive(8'h01);
        drive(8'h12);
        repeat (TMO - 1) @(negedge CLK_50);
        expect_write(0, 16'h1234);
        drive(8'h34);
        check_status("tmo_edge_lo", 5'b10100);
        drive(8'h46);
        check_status("tmo_edge_end", 5'b01010);
        check_drained("tmo_edge");

        // Reset lands while the low byte is being presented: its write must never appear.
        drive(8'hA5);
        drive(8'h01);
        drive(8'h56);
        rx_valid = 1'b1;
        rx_data  = 8'h78;
        #5 resetN = 1'b0;
        @(negedge CLK_50);
        rx_valid = 1'b0;
        check_status("midrst", 5'b01000);
        check("midrst_addr_b", {22'd0, ram_addr_b}, 32'd0);
        check("midrst_wdata", {ram_wdata_a, ram_wdata_b}, 32'd0);
        resetN = 1'b1;
        @(negedge CLK_50);
        check_status("midrst_rel", 5'b01000);
        check_drained("midrst");

        words[0] = 16'h0007;
        send_frame("recover", 8'h01, 1, 8'h07, 1, 5'b01010);

        repeat (2) @(negedge CLK_50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
